sram_like_mem_resp: RTL and testbench

Responder (slave) end of the SRAM-like request/response protocol used by the pipeline's instruction and data ports. It accepts address-phase requests (`req`/`addrok`) into an in-order outstanding queue, performs reads and writes against an internal word-addressed memory, and returns each result with a one-cycle `dataok` pulse after a fixed latency. It serves as the memory behind the fetch and memory stages in simulation and in the standalone memory subsystem, and lets those stages be exercised under latency and back-pressure.

---
 rtl/sram_like_mem_resp.sv | 61 ++++++
 tb/tb_sram_like_mem_resp.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sram_like_mem_resp.sv
// sram_like_mem_resp: SRAM-like responder with word memory, in-order outstanding queue and fixed-latency dataok
module sram_like_mem_resp #(
  parameter int ADDR_BITS = 12,
  parameter int LATENCY = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_req,
  input  logic        sram_wr,
  input  logic [1:0]  sram_size,
  input  logic [31:0] sram_addr,
  input  logic [3:0]  sram_wstrb,
  input  logic [31:0] sram_wdata,
  input  logic        addrok_mask,
  output logic        sram_addrok,
  output logic        sram_dataok,
  output logic [31:0] sram_rdata
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam logic [3:0] CD_INIT = 4'(LATENCY - 1);
  logic [31:0] r_mem [2**ADDR_BITS];
  logic [31:0] r_data [MAX_OUTSTANDING];
  logic [3:0] r_cd [MAX_OUTSTANDING];
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0] r_count;
  logic w_push, w_pop, w_unused;
  logic [ADDR_BITS-1:0] w_idx;
  assign w_unused = ^{sram_size, sram_addr[31:ADDR_BITS+2], sram_addr[1:0]};
  assign w_idx = sram_addr[ADDR_BITS+1:2];
  // full exactly when the count MSB is set, since depth is a power of two
  assign sram_addrok = !reset && !r_count[PW] && !addrok_mask;
  assign w_push = sram_req && sram_addrok;
  assign w_pop = !reset && r_count != '0 && r_cd[r_head] == '0;
  assign sram_dataok = w_pop;
  assign sram_rdata = w_pop ? r_data[r_head] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end
  // read data is captured before this edge's write lands; writes queue a zero response
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (w_push && r_tail == PW'(i)) begin
        r_cd[i] <= CD_INIT;
        r_data[i] <= sram_wr ? '0 : r_mem[w_idx];
      end else if (r_cd[i] != '0) begin
        r_cd[i] <= r_cd[i] - 4'd1;
      end
    end
    for (int b = 0; b < 4; b++)
      if (w_push && sram_wr && sram_wstrb[b]) r_mem[w_idx][8*b +: 8] <= sram_wdata[8*b +: 8];
  end
endmodule

// File: tb/tb_sram_like_mem_resp.sv
// tb_sram_like_mem_resp: table vectors plus scoreboard on a LATENCY=2 instance, full-queue and reset corners on a LATENCY=8 instance
module tb_sram_like_mem_resp;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset = 1, req = 0, wr = 0, mask = 0;
  logic [31:0] addr = 0, wdata = 0, drv_exp = 0;
  logic [3:0] wstrb = 0;
  logic addrok, dataok;
  logic [31:0] rdata;
  logic f_reset = 1, f_req = 0, f_wr = 0;
  logic [31:0] f_addr = 0, f_wdata = 0;
  logic [3:0] f_wstrb = 0;
  logic f_addrok, f_dataok;
  logic [31:0] f_rdata;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {logic [31:0] data; int due;} sb_t;
  sb_t sb[$];
  typedef struct {logic w; logic [31:0] a; logic [3:0] s; logic [31:0] d; logic [31:0] e;} vec_t;

  sram_like_mem_resp #(.ADDR_BITS(12), .LATENCY(2), .MAX_OUTSTANDING(4)) u_dut (
    .clk(clk), .reset(reset), .sram_req(req), .sram_wr(wr), .sram_size(2'd2),
    .sram_addr(addr), .sram_wstrb(wstrb), .sram_wdata(wdata), .addrok_mask(mask),
    .sram_addrok(addrok), .sram_dataok(dataok), .sram_rdata(rdata));
  sram_like_mem_resp #(.ADDR_BITS(12), .LATENCY(8), .MAX_OUTSTANDING(4)) u_fq (
    .clk(clk), .reset(f_reset), .sram_req(f_req), .sram_wr(f_wr), .sram_size(2'd2),
    .sram_addr(f_addr), .sram_wstrb(f_wstrb), .sram_wdata(f_wdata), .addrok_mask(1'b0),
    .sram_addrok(f_addrok), .sram_dataok(f_dataok), .sram_rdata(f_rdata));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  always @(posedge clk) cyc++;

  // scoreboard: expected response pushed at acceptance, popped when due
  always @(negedge clk) begin
    logic e_pop, e_ok;
    e_pop = !reset && sb.size() > 0 && sb[0].due == cyc;
    e_ok = !reset && sb.size() < 4 && !mask;
    chk("addrok", 32'(addrok), 32'(e_ok));
    chk("dataok", 32'(dataok), 32'(e_pop));
    chk("rdata", rdata, e_pop ? sb[0].data : 32'h0);
    if (e_pop) void'(sb.pop_front());
    if (reset) sb.delete();
    else if (req && e_ok) sb.push_back('{drv_exp, cyc + 2});
  end

  task automatic put(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input logic [31:0] e);
    req = 1; wr = w; addr = a; wstrb = s; wdata = d; drv_exp = e;
    for (int i = 0; i <= 50; i++) begin
      @(negedge clk);
      if (addrok) break;
      if (i == 50) fail("accept");
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n);
    req = 0; wr = 0;
    repeat (n) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'h0);
  endtask

  task automatic fput(input logic w, input logic [31:0] a, input logic [31:0] d);
    f_req = 1; f_wr = w; f_addr = a; f_wdata = d; f_wstrb = 4'hF;
    for (int i = 0; i <= 50; i++) begin
      @(negedge clk);
      if (f_addrok) break;
      if (i == 50) fail("f_accept");
    end
    @(posedge clk); #1;
    f_req = 0; f_wr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [12];
    int n, start;
    bit got;
    tbl[0]  = '{1'b1, 32'h100,  4'hF, 32'h12345678, 32'h0};
    tbl[1]  = '{1'b0, 32'h100,  4'h0, 32'h0,        32'h12345678};
    tbl[2]  = '{1'b1, 32'h100,  4'h5, 32'hAABBCCDD, 32'h0};
    tbl[3]  = '{1'b0, 32'h100,  4'h0, 32'h0,        32'h12BB56DD};
    tbl[4]  = '{1'b1, 32'h4000, 4'hF, 32'h11111111, 32'h0};
    tbl[5]  = '{1'b0, 32'h0,    4'h0, 32'h0,        32'h11111111};
    tbl[6]  = '{1'b1, 32'h204,  4'hF, 32'h0,        32'h0};
    tbl[7]  = '{1'b1, 32'h204,  4'hA, 32'hDEADBEEF, 32'h0};
    tbl[8]  = '{1'b0, 32'h204,  4'h0, 32'h0,        32'hDE00BE00};
    tbl[9]  = '{1'b1, 32'h4004, 4'hF, 32'h55AA55AA, 32'h0};
    tbl[10] = '{1'b0, 32'h8004, 4'h0, 32'h0,        32'h55AA55AA};
    tbl[11] = '{1'b0, 32'h4,    4'h0, 32'h0,        32'h55AA55AA};
    repeat (3) @(posedge clk);
    #1 reset = 0; f_reset = 0;
    for (int i = 0; i < 12; i++) put(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d, tbl[i].e);
    drain(6);
    mask = 1;
    start = cyc;
    fork begin repeat (3) @(posedge clk); #1 mask = 0; end join_none
    put(1'b0, 32'h100, 4'h0, 32'h0, 32'h12BB56DD);
    chk("mask_accept_cycle", 32'(cyc - start), 32'd4);
    drain(6);
    for (int i = 0; i < 10; i++) put(1'b1, 32'h300 + 32'(4*i), 4'hF, 32'hA5000000 | 32'(i*32'h111), 32'h0);
    for (int i = 0; i < 10; i++) put(1'b0, 32'h300 + 32'(4*i), 4'h0, 32'h0, 32'hA5000000 | 32'(i*32'h111));
    drain(6);
    for (int i = 0; i < 5; i++) fput(1'b1, 32'(4*i), 32'hF0000000 + 32'(i));
    fput(1'b1, 32'h40, 32'hCAFEF00D);
    repeat (12) @(posedge clk);
    #1;
    n = 0; f_req = 1; f_wr = 0; f_addr = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("fq_addrok", 32'(f_addrok), 32'(k <= 3 || k >= 9));
      chk("fq_dataok", 32'(f_dataok), 32'((k >= 8 && k <= 11) || k == 17));
      chk("fq_rdata", f_rdata, (k >= 8 && k <= 11) ? 32'hF0000000 + 32'(k - 8) : (k == 17 ? 32'hF0000004 : 32'h0));
      if (f_req && f_addrok) n++;
      @(posedge clk); #1;
      f_req = n < 5; f_addr = 32'(n*4);
    end
    f_req = 1; f_addr = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k == 3) begin
        chk("rst_addrok", 32'(f_addrok), 32'h0);
        chk("rst_rdata", f_rdata, 32'h0);
      end
      if (k == 4) chk("post_rst_addrok", 32'(f_addrok), 32'h1);
      if (k >= 3) chk("dropped_dataok", 32'(f_dataok), 32'h0);
      @(posedge clk); #1;
      f_req = k < 1; f_addr = 32'(4*(k+1)); f_reset = (k == 2);
      if (k == 1) f_req = 1;
    end
    fput(1'b0, 32'h40, 32'h0);
    got = 0;
    for (int i = 0; i < 15 && !got; i++) begin
      @(negedge clk);
      if (f_dataok) begin
        got = 1;
        chk("reset_persist", f_rdata, 32'hCAFEF00D);
      end
    end
    if (!got) fail("reset_persist");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
